// File: rtl/dm_store_buffer.sv
// Posted-write store queue in front of the data memory write port.
// Drains one store per cycle and flags loads that overlap any pending store.
module dm_store_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 12,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          st_valid,
   output logic          st_ready,
   input  logic [AW-1:0] st_addr,
   input  logic [31:0]   st_data,
   input  logic [1:0]    st_size,
   input  logic [31:0]   st_pc,
   output logic          st_err,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   input  logic [1:0]    ld_size,
   output logic          ld_hazard,
   input  logic          dm_hold,
   output logic          dm_we,
   output logic [1:0]    dm_memdst,
   output logic [AW-1:0] dm_addr,
   output logic [31:0]   dm_wdata,
   output logic [31:0]   dm_iaddr,
   output logic [CW-1:0] count,
   output logic          empty
);

   logic [AW-1:0] addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [1:0]    size_q [DEPTH];
   logic [31:0]   pc_q   [DEPTH];

   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          st_err_q;
   logic          illegal, enq, deq;

   // The illegal size code 2 is sized as a word so hazard checks stay conservative.
   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      case (sz)
         2'd0:    size_bytes = 3'd1;
         2'd1:    size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

   assign illegal = (st_size == 2'd2) ||
                    ((st_size == 2'd1) && st_addr[0]) ||
                    ((st_size == 2'd3) && (st_addr[1:0] != 2'b00));

   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign st_ready = (count_q < CW'(DEPTH));
   assign st_err   = st_err_q;
   assign enq      = st_valid && st_ready && !illegal;
   assign deq      = dm_we;

   assign dm_we     = !empty && !dm_hold;
   assign dm_memdst = empty ? 2'd0     : size_q[rd_ptr_q];
   assign dm_addr   = empty ? '0       : addr_q[rd_ptr_q];
   assign dm_wdata  = empty ? 32'd0    : data_q[rd_ptr_q];
   assign dm_iaddr  = empty ? 32'd0    : pc_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      case ({enq, deq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         st_err_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         st_err_q <= st_valid && st_ready && illegal;
         if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && enq) begin
         addr_q[wr_ptr_q] <= st_addr;
         data_q[wr_ptr_q] <= st_data;
         size_q[wr_ptr_q] <= st_size;
         pc_q[wr_ptr_q]   <= st_pc;
      end
   end

   // An entry is live when its distance from the head is below the occupancy.
   logic [PW-1:0] offs;
   logic [AW:0]   s_lo, s_hi, l_lo, l_hi;

   always_comb begin
      ld_hazard = 1'b0;
      offs      = '0;
      s_lo      = '0;
      s_hi      = '0;
      l_lo      = {1'b0, ld_addr};
      l_hi      = {1'b0, ld_addr} + (AW+1)'(size_bytes(ld_size));
      for (int unsigned i = 0; i < DEPTH; i++) begin
         offs = PW'(i) - rd_ptr_q;
         s_lo = {1'b0, addr_q[i]};
         s_hi = {1'b0, addr_q[i]} + (AW+1)'(size_bytes(size_q[i]));
         if (ld_valid && ({1'b0, offs} < count_q) && (s_lo < l_hi) && (l_lo < s_hi)) begin
            ld_hazard = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed self-checking bench for dm_store_buffer with hand-computed expectations.
module tb_dm_store_buffer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic          st_valid;
   logic          st_ready;
   logic [AW-1:0] st_addr;
   logic [31:0]   st_data;
   logic [1:0]    st_size;
   logic [31:0]   st_pc;
   logic          st_err;
   logic          ld_valid;
   logic [AW-1:0] ld_addr;
   logic [1:0]    ld_size;
   logic          ld_hazard;
   logic          dm_hold;
   logic          dm_we;
   logic [1:0]    dm_memdst;
   logic [AW-1:0] dm_addr;
   logic [31:0]   dm_wdata;
   logic [31:0]   dm_iaddr;
   logic [2:0]    count;
   logic          empty;

   int checks = 0;
   int errors = 0;

   dm_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
      .st_size(st_size), .st_pc(st_pc), .st_err(st_err),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size), .ld_hazard(ld_hazard),
      .dm_hold(dm_hold), .dm_we(dm_we), .dm_memdst(dm_memdst), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_iaddr(dm_iaddr), .count(count), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [1:0] sz, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [31:0] pc);
      st_valid = 1'b1;
      st_size  = sz;
      st_addr  = a;
      st_data  = d;
      st_pc    = pc;
      tick();
      st_valid = 1'b0;
      #1;
   endtask

   task automatic load(input logic [1:0] sz, input logic [AW-1:0] a);
      ld_valid = 1'b1;
      ld_size  = sz;
      ld_addr  = a;
      #1;
   endtask

   logic [AW-1:0] exp_addr [4];
   logic [31:0]   exp_data [4];
   logic [1:0]    exp_size [4];

   initial begin
      reset = 1'b1; st_valid = 0; st_addr = 0; st_data = 0; st_size = 0; st_pc = 0;
      ld_valid = 0; ld_addr = 0; ld_size = 0; dm_hold = 0;
      tick(); tick();
      reset = 1'b0;
      repeat (5) tick();
      #1;
      check("rst_we", 32'(dm_we), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_ready", 32'(st_ready), 32'd1);
      check("rst_err", 32'(st_err), 32'd0);

      // Single word store, minimum latency.
      push(2'd3, 12'h010, 32'h12345678, 32'h00003000);
      check("sw_we", 32'(dm_we), 32'd1);
      check("sw_memdst", 32'(dm_memdst), 32'd3);
      check("sw_addr", 32'(dm_addr), 32'h010);
      check("sw_wdata", dm_wdata, 32'h12345678);
      check("sw_iaddr", dm_iaddr, 32'h00003000);
      tick(); #1;
      check("sw_count_after", 32'(count), 32'd0);
      check("sw_we_after", 32'(dm_we), 32'd0);

      // Fill under hold, refuse fifth, drain in order.
      dm_hold = 1'b1;
      exp_addr = '{12'h001, 12'h002, 12'h004, 12'h008};
      exp_data = '{32'h000000AA, 32'h0000BBBB, 32'hCCCCCCCC, 32'h000000DD};
      exp_size = '{2'd0, 2'd1, 2'd3, 2'd0};
      for (int i = 0; i < 4; i++) push(exp_size[i], exp_addr[i], exp_data[i], 32'h100 + 32'(i));
      check("full_count", 32'(count), 32'd4);
      check("full_ready", 32'(st_ready), 32'd0);
      check("full_hold_we", 32'(dm_we), 32'd0);
      push(2'd3, 12'h00C, 32'hEEEEEEEE, 32'h200);
      check("full_reject_count", 32'(count), 32'd4);
      dm_hold = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain%0d_we", i), 32'(dm_we), 32'd1);
         check($sformatf("drain%0d_addr", i), 32'(dm_addr), 32'(exp_addr[i]));
         check($sformatf("drain%0d_data", i), dm_wdata, exp_data[i]);
         check($sformatf("drain%0d_size", i), 32'(dm_memdst), 32'(exp_size[i]));
         check($sformatf("drain%0d_pc", i), dm_iaddr, 32'h100 + 32'(i));
         tick(); #1;
      end
      check("drain_empty", 32'(empty), 32'd1);
      check("drain_we_off", 32'(dm_we), 32'd0);

      // Load hazard detection.
      dm_hold = 1'b1;
      push(2'd0, 12'h013, 32'h00000011, 32'h300);
      load(2'd3, 12'h010);
      check("haz_lw010", 32'(ld_hazard), 32'd1);
      load(2'd3, 12'h014);
      check("haz_lw014", 32'(ld_hazard), 32'd0);
      load(2'd1, 12'h012);
      check("haz_lh012", 32'(ld_hazard), 32'd1);
      load(2'd0, 12'h012);
      check("haz_lb012", 32'(ld_hazard), 32'd0);
      ld_valid = 1'b0; #1;
      check("haz_novalid", 32'(ld_hazard), 32'd0);
      dm_hold = 1'b0;
      tick(); #1;
      load(2'd3, 12'h010);
      check("haz_after_drain", 32'(ld_hazard), 32'd0);
      ld_valid = 1'b0;

      // Illegal stores are dropped with a one-cycle error pulse.
      push(2'd1, 12'h011, 32'h1111, 32'h400);
      check("err_sh_pulse", 32'(st_err), 32'd1);
      check("err_sh_count", 32'(count), 32'd0);
      check("err_sh_we", 32'(dm_we), 32'd0);
      tick(); #1;
      check("err_sh_clear", 32'(st_err), 32'd0);
      push(2'd3, 12'h006, 32'h2222, 32'h404);
      check("err_sw_pulse", 32'(st_err), 32'd1);
      check("err_sw_count", 32'(count), 32'd0);
      check("err_sw_we", 32'(dm_we), 32'd0);
      tick(); #1;
      check("err_sw_clear", 32'(st_err), 32'd0);
      push(2'd2, 12'h020, 32'h3333, 32'h408);
      check("err_sz2_pulse", 32'(st_err), 32'd1);
      check("err_sz2_count", 32'(count), 32'd0);
      tick(); #1;
      check("err_sz2_clear", 32'(st_err), 32'd0);
      check("err_sz2_we", 32'(dm_we), 32'd0);

      // Reset discards pending stores.
      dm_hold = 1'b1;
      push(2'd3, 12'h030, 32'hA0A0A0A0, 32'h500);
      push(2'd3, 12'h034, 32'hB0B0B0B0, 32'h504);
      push(2'd3, 12'h038, 32'hC0C0C0C0, 32'h508);
      check("prerst_count", 32'(count), 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("postrst_count", 32'(count), 32'd0);
      check("postrst_empty", 32'(empty), 32'd1);
      check("postrst_ready", 32'(st_ready), 32'd1);
      dm_hold = 1'b0;
      load(2'd3, 12'h030);
      check("postrst_haz", 32'(ld_hazard), 32'd0);
      ld_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("postrst_we%0d", i), 32'(dm_we), 32'd0);
         tick();
      end

      // Simultaneous enqueue and dequeue at count 2.
      dm_hold = 1'b1;
      push(2'd3, 12'h040, 32'h00000001, 32'h600);
      push(2'd3, 12'h044, 32'h00000002, 32'h604);
      check("sim_pre_count", 32'(count), 32'd2);
      dm_hold  = 1'b0;
      st_valid = 1'b1; st_size = 2'd3; st_addr = 12'h048; st_data = 32'h3; st_pc = 32'h608;
      #1;
      check("sim_we", 32'(dm_we), 32'd1);
      check("sim_head", 32'(dm_addr), 32'h040);
      tick();
      st_valid = 1'b0;
      #1;
      check("sim_count", 32'(count), 32'd2);
      check("sim_head2", 32'(dm_addr), 32'h044);
      tick(); #1;
      check("sim_head3", 32'(dm_addr), 32'h048);
      check("sim_head3_data", dm_wdata, 32'h3);
      tick(); #1;
      check("sim_final_empty", 32'(empty), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Posted-write FIFO sitting directly upstream of the byte-addressed data memory's write port.
- Accepts sb/sh/sw requests from the execute/memory stage and queues them with their instruction address.
- Drains one store per cycle into the data memory using its MemDst size encoding, and flags loads that overlap any pending store so the pipeline stalls instead of reading stale data.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- AW, 12, byte address width; matches the data memory address port.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high; clears queue state
- st_valid  input  1  store request present
- st_ready  output  1  queue can accept a store this cycle
- st_addr  input  AW  store byte address
- st_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- st_size  input  2  0=byte, 1=half, 3=word; 2 is illegal
- st_pc  input  32  address of the store instruction
- st_err  output  1  registered one-cycle pulse: previous offered store was misaligned or illegal and was dropped
- ld_valid  input  1  load being issued this cycle
- ld_addr  input  AW  load byte address
- ld_size  input  2  same encoding as st_size
- ld_hazard  output  1  load overlaps a queued store; requester must stall
- dm_hold  input  1  data memory write port unavailable this cycle
- dm_we  output  1  write enable to the data memory
- dm_memdst  output  2  size code to the data memory
- dm_addr  output  AW  write address to the data memory
- dm_wdata  output  32  write data to the data memory
- dm_iaddr  output  32  instruction address forwarded for the write trace
- count  output  clog2(DEPTH)+1  number of queued entries
- empty  output  1  count==0

Behaviour:
- Each entry holds addr, data, size, and pc. Circular FIFO with read/write pointers and an occupancy counter.
- st_ready = (count < DEPTH), evaluated combinationally.
  - st_ready does not depend on the dequeue in the same cycle, so a full queue never accepts.
  - st_ready does not depend on alignment.
- Alignment check on an offered store (st_valid && st_ready):
  - size 1 with addr[0]=1 is illegal.
  - size 3 with addr[1:0]!=0 is illegal.
  - size 2 is always illegal.
  - An illegal store is consumed but not enqueued: st_err=1 in the next cycle only, and count is unchanged.
- Enqueue: a legal store with st_valid && st_ready is written at the rising edge.
- Drain outputs are driven combinationally from the head entry:
  - dm_we = !empty && !dm_hold.
  - dm_memdst, dm_addr, dm_wdata, dm_iaddr come from the head entry.
  - When empty, these outputs are 0.
- Dequeue: when dm_we=1, the head advances at the same rising edge at which the data memory commits the write.
- Minimum latency: a store accepted at edge N appears on dm_* in cycle N+1 and commits at edge N+1. There is no bypass of an empty queue.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Order is strictly FIFO.
- ld_hazard is combinational:
  - Asserted when ld_valid=1 and any valid entry's byte range [addr, addr+n) intersects [ld_addr, ld_addr+m).
  - n and m are 1, 2, or 4, from the respective size codes.
  - The store being offered in the same cycle is not considered.
  - The entry being dequeued in the current cycle still counts.
- Address arithmetic needs no wrap handling, because aligned accesses never cross 2^AW.
- dm_hold=1 freezes the head. Enqueue continues until full.
- Reset (synchronous, active-high), effective at the edge:
  - Pointers and count go to 0.
  - st_err goes to 0.
  - All pending stores are discarded without writing.
  - After reset: dm_we=0, empty=1, ld_hazard=0, st_ready=1.
- Reset has priority over simultaneous enqueue and dequeue.

Test Plan:
- Reset, then idle 5 cycles -> dm_we=0, count=0, empty=1, st_ready=1, st_err=0.
- Push sw addr 0x010, data 0x12345678, pc 0x00003000 -> next cycle dm_we=1, dm_memdst=3, dm_addr=0x010, dm_wdata=0x12345678, dm_iaddr=0x00003000; the following cycle count=0.
- dm_hold=1, push sb 0x001/0xAA, sh 0x002/0xBBBB, sw 0x004/0xCCCCCCCC, sb 0x008/0xDD -> count=4, st_ready=0; a fifth push is not accepted. Drop dm_hold -> four consecutive dm_we pulses in push order, then empty=1.
- dm_hold=1, queued sb 0x013 -> lw 0x010 gives ld_hazard=1; lw 0x014 gives 0; lh 0x012 gives 1. Release dm_hold; after the drain, lw 0x010 gives 0.
- Push sh 0x011, then sw 0x006, then size 2 at 0x020 -> each is dropped, st_err=1 for exactly one cycle after each, count stays 0, dm_we never asserted.
- dm_hold=1 with 3 queued, then reset=1 for one cycle -> next cycle count=0, dm_we=0, and no write of those entries ever occurs. At count=2 with push and drain in the same cycle -> count remains 2.
